// File: rtl/nav_msg_gen.sv
// ---------------------------------------------------------------------------
// nav_msg_gen
// Generates a GPS LNAV-style navigation bit stream (TLM, HOW, filler words,
// IS-GPS-200 parity) for the msg_in input of the signal generator core. Bit
// timing is locked to the C/A epoch pulse: every EPOCHS_PER_BIT epochs a new
// bit is presented, so bit edges always coincide with code epochs.
//
// Ports
//   clk_in          system clock
//   rst_in_n        synchronous reset, active low
//   ena_in          run enable; dropping it returns the block to IDLE
//   epoch_in        1-cycle C/A epoch pulse
//   tow_load_in     1-cycle pulse: load tow_in into the TOW counter
//   tow_in[16:0]    TOW count in 6 s units, 0..100799 (larger loads as 0)
//   msg_out         current transmitted nav bit
//   bit_strobe_out  1-cycle pulse when msg_out takes a new bit
//   sf_start_out    1-cycle pulse with the strobe of bit 1 of word 1
//   sf_id_out[2:0]  subframe ID being sent, 1..5
// ---------------------------------------------------------------------------
module nav_msg_gen #(
    parameter int unsigned EPOCHS_PER_BIT = 20,
    parameter logic [13:0] TLM_MSG        = 14'h0000,
    parameter logic [23:0] FILLER         = 24'hAAAAAA
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic        ena_in,
    input  logic        epoch_in,
    input  logic        tow_load_in,
    input  logic [16:0] tow_in,
    output logic        msg_out,
    output logic        bit_strobe_out,
    output logic        sf_start_out,
    output logic [2:0]  sf_id_out
);

    localparam logic [16:0]  TOW_MAX = 17'd100799;
    localparam int unsigned  EW      = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;
    localparam logic [EW-1:0] EP_LAST = EW'(EPOCHS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUILD = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

    // Parity bits D25..D30 (p[5]..p[0]) from source data d1..d24 (d[23] = d1).
    function automatic logic [5:0] lnav_parity(input logic [23:0] d,
                                               input logic d29s,
                                               input logic d30s);
        logic [5:0] p;
        p[5] = d29s ^ (^(d & 24'hEC7CD2));
        p[4] = d30s ^ (^(d & 24'h763E69));
        p[3] = d29s ^ (^(d & 24'hBB1F34));
        p[2] = d30s ^ (^(d & 24'h5D8F9A));
        p[1] = d30s ^ (^(d & 24'hAEC7CD));
        p[0] = d29s ^ (^(d & 24'h2DEA27));
        return p;
    endfunction

    // Full 30-bit transmitted word: data inverted when D30* is set, then parity.
    function automatic logic [29:0] lnav_word(input logic [23:0] d,
                                              input logic d29s,
                                              input logic d30s);
        return {d ^ {24{d30s}}, lnav_parity(d, d29s, d30s)};
    endfunction

    state_t          state_r;
    logic [29:0]     shift_r;
    logic [4:0]      bit_cnt_r;      // bits of the current word already sent
    logic [3:0]      word_idx_r;     // 0 = TLM, 1 = HOW, 2..9 = filler
    logic [EW-1:0]   epoch_cnt_r;    // 0 means the next epoch emits a bit
    logic [16:0]     tow_r;
    logic [16:0]     tow_pend_r;
    logic            tow_pend_vld_r;
    logic            d29_star_r;
    logic            d30_star_r;
    logic            d29_word_r;     // D29/D30 of the word in flight
    logic            d30_word_r;

    logic [16:0]     tow_inc_s;
    logic [16:0]     tow_load_val_s;
    logic [23:0]     data_s;
    logic [29:0]     word_s;
    logic            epoch_emit_s;
    logic [EW-1:0]   epoch_cnt_nxt_s;

    // TOW arithmetic: modulo increment and clamped load value.
    always_comb begin
        if (tow_r == TOW_MAX) begin
            tow_inc_s = 17'd0;
        end else begin
            tow_inc_s = tow_r + 17'd1;
        end
        if (tow_in > TOW_MAX) begin
            tow_load_val_s = 17'd0;
        end else begin
            tow_load_val_s = tow_in;
        end
    end

    // Data bits of the word selected by word_idx_r and its encoded form.
    always_comb begin
        case (word_idx_r)
            4'd0:    data_s = {8'h8B, TLM_MSG, 2'b00};
            // HOW carries the TOW of the next subframe; alert and A-S are 0.
            4'd1:    data_s = {tow_inc_s, 1'b0, 1'b0, sf_id_out, 2'b00};
            default: data_s = FILLER;
        endcase
        word_s = lnav_word(data_s, d29_star_r, d30_star_r);
    end

    // Epoch counter: the first epoch after start emits, then every EPOCHS_PER_BIT-th.
    always_comb begin
        epoch_emit_s = epoch_in && (epoch_cnt_r == {EW{1'b0}});
        if (epoch_cnt_r == EP_LAST) begin
            epoch_cnt_nxt_s = {EW{1'b0}};
        end else begin
            epoch_cnt_nxt_s = epoch_cnt_r + EW'(1);
        end
    end

    // Main FSM: word build, bit emission, subframe and TOW bookkeeping.
    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            state_r        <= ST_IDLE;
            shift_r        <= 30'd0;
            bit_cnt_r      <= 5'd0;
            word_idx_r     <= 4'd0;
            epoch_cnt_r    <= {EW{1'b0}};
            tow_r          <= 17'd0;
            tow_pend_r     <= 17'd0;
            tow_pend_vld_r <= 1'b0;
            d29_star_r     <= 1'b0;
            d30_star_r     <= 1'b0;
            d29_word_r     <= 1'b0;
            d30_word_r     <= 1'b0;
            msg_out        <= 1'b0;
            bit_strobe_out <= 1'b0;
            sf_start_out   <= 1'b0;
            sf_id_out      <= 3'd1;
        end else if (!ena_in) begin
            // Stream restarts from word 1 of subframe 1; TOW is preserved.
            state_r        <= ST_IDLE;
            bit_cnt_r      <= 5'd0;
            word_idx_r     <= 4'd0;
            epoch_cnt_r    <= {EW{1'b0}};
            d29_star_r     <= 1'b0;
            d30_star_r     <= 1'b0;
            msg_out        <= 1'b0;
            bit_strobe_out <= 1'b0;
            sf_start_out   <= 1'b0;
            sf_id_out      <= 3'd1;
            if (tow_load_in) begin
                tow_r <= tow_load_val_s;
            end
        end else begin
            bit_strobe_out <= 1'b0;
            sf_start_out   <= 1'b0;
            // Epochs keep counting in BUILD so bit spacing never slips.
            if ((state_r != ST_IDLE) && epoch_in) begin
                epoch_cnt_r <= epoch_cnt_nxt_s;
            end
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_BUILD;
                    if (tow_load_in) begin
                        tow_r <= tow_load_val_s;
                    end
                end
                ST_BUILD: begin
                    d29_word_r <= word_s[1];
                    d30_word_r <= word_s[0];
                    // An emitting epoch here sends bit 1 straight from the new word.
                    if (epoch_emit_s) begin
                        msg_out        <= word_s[29];
                        bit_strobe_out <= 1'b1;
                        sf_start_out   <= (word_idx_r == 4'd0);
                        shift_r        <= {word_s[28:0], 1'b0};
                        bit_cnt_r      <= 5'd1;
                        state_r        <= ST_SEND;
                    end else begin
                        shift_r   <= word_s;
                        bit_cnt_r <= 5'd0;
                        state_r   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (epoch_emit_s) begin
                        msg_out        <= shift_r[29];
                        bit_strobe_out <= 1'b1;
                        sf_start_out   <= (word_idx_r == 4'd0);
                        shift_r        <= {shift_r[28:0], 1'b0};
                        bit_cnt_r      <= 5'd1;
                        state_r        <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (epoch_emit_s) begin
                        msg_out        <= shift_r[29];
                        bit_strobe_out <= 1'b1;
                        shift_r        <= {shift_r[28:0], 1'b0};
                        if (bit_cnt_r == 5'd29) begin
                            bit_cnt_r  <= 5'd0;
                            state_r    <= ST_BUILD;
                            d29_star_r <= d29_word_r;
                            d30_star_r <= d30_word_r;
                            if (word_idx_r == 4'd9) begin
                                word_idx_r     <= 4'd0;
                                sf_id_out      <= (sf_id_out == 3'd5) ? 3'd1 : (sf_id_out + 3'd1);
                                tow_r          <= tow_pend_vld_r ? tow_pend_r : tow_inc_s;
                                tow_pend_vld_r <= 1'b0;
                            end else begin
                                word_idx_r <= word_idx_r + 4'd1;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
            // Running loads wait for the subframe end; a load landing on that
            // very edge is kept for the following subframe end.
            if (tow_load_in && (state_r != ST_IDLE)) begin
                tow_pend_r     <= tow_load_val_s;
                tow_pend_vld_r <= 1'b1;
            end
        end
    end

endmodule
